// File: rtl/reflector_pkg.sv
// Shared definitions for the programmable reflector: default sizes, FSM states
// and the letter helpers used by both the table and the control logic.
package reflector_pkg;

  localparam int ALPHA_DEF = 26;
  localparam int W_DEF     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_APPLY,
    ST_FAIL
  } state_t;

  // Half-alphabet rotation: the wiring the reflector powers up with.
  function automatic int default_map(input int i, input int alpha);
    return (i <= alpha / 2) ? i + alpha / 2 : i - alpha / 2;
  endfunction

  function automatic logic in_range(input int x, input int alpha);
    return (x >= 1) && (x <= alpha);
  endfunction

endpackage

// File: rtl/reflector_prog_if.sv
// Letter path and configuration port of the reflector, grouped as one bundle.
// Handshake: a letter or pair transfers on any cycle its valid is high (no ready).
interface reflector_prog_if #(parameter int W = reflector_pkg::W_DEF);

  logic         in_valid;
  logic [W-1:0] in_letter;
  logic         out_valid;
  logic [W-1:0] out_letter;
  logic         out_err;
  logic         cfg_start;
  logic         cfg_valid;
  logic [W-1:0] cfg_a;
  logic [W-1:0] cfg_b;
  logic         cfg_commit;
  logic         cfg_busy;
  logic         cfg_ok;
  logic         cfg_fail;

  modport master (
    output in_valid, in_letter, cfg_start, cfg_valid, cfg_a, cfg_b, cfg_commit,
    input  out_valid, out_letter, out_err, cfg_busy, cfg_ok, cfg_fail
  );

  modport slave (
    input  in_valid, in_letter, cfg_start, cfg_valid, cfg_a, cfg_b, cfg_commit,
    output out_valid, out_letter, out_err, cfg_busy, cfg_ok, cfg_fail
  );

endinterface

// File: rtl/reflector_table.sv
// Active and shadow wiring tables. Out-of-range addresses read back as 0 so the
// checker sees a missing partner rather than an arbitrary entry.
module reflector_table
  import reflector_pkg::*;
#(
  parameter int ALPHA = ALPHA_DEF,
  parameter int W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_rd_addr,
  output logic [W-1:0] o_rd_data,
  input  logic [W-1:0] i_chk_addr,
  output logic [W-1:0] o_chk_data,
  output logic [W-1:0] o_chk_back,
  input  logic         i_clr,
  input  logic         i_wr,
  input  logic [W-1:0] i_wr_a,
  input  logic [W-1:0] i_wr_b,
  input  logic         i_copy
);

  logic [W-1:0] r_act [1:ALPHA];
  logic [W-1:0] r_shd [1:ALPHA];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= ALPHA; i++) begin
        r_act[i] <= W'(default_map(i, ALPHA));
        r_shd[i] <= '0;
      end
    end else begin
      if (i_copy) begin
        for (int i = 1; i <= ALPHA; i++) r_act[i] <= r_shd[i];
      end
      if (i_clr) begin
        for (int i = 1; i <= ALPHA; i++) r_shd[i] <= '0;
      end else if (i_wr) begin
        r_shd[i_wr_a] <= i_wr_b;
        r_shd[i_wr_b] <= i_wr_a;
      end
    end
  end

  assign o_rd_data  = in_range(int'(i_rd_addr), ALPHA)  ? r_act[i_rd_addr]  : '0;
  assign o_chk_data = in_range(int'(i_chk_addr), ALPHA) ? r_shd[i_chk_addr] : '0;
  // Partner's partner, needed to confirm the wiring is an involution.
  assign o_chk_back = in_range(int'(o_chk_data), ALPHA) ? r_shd[o_chk_data] : '0;

endmodule

// File: rtl/reflector_prog.sv
// Programmable reflector: registered letter translation through the active table,
// plus a load/check/apply FSM that swaps in a new wiring without stalling letters.
module reflector_prog
  import reflector_pkg::*;
#(
  parameter int ALPHA = ALPHA_DEF,
  parameter int W     = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  reflector_prog_if.slave  bus,
  output state_t           o_dbg_state
);

  state_t       r_state, w_next;
  logic [W-1:0] r_idx, w_idx_next;
  logic         r_bad, w_bad_set, w_bad_clr;
  logic         w_clr, w_wr, w_copy;
  logic [W-1:0] w_act_rd, w_chk_d, w_chk_back;
  logic         w_in_ok, w_pair_ok, w_entry_fail;
  logic         r_out_valid, r_out_err, r_ok, r_fail;
  logic [W-1:0] r_out_letter;

  reflector_table #(.ALPHA(ALPHA), .W(W)) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_rd_addr  (bus.in_letter),
    .o_rd_data  (w_act_rd),
    .i_chk_addr (r_idx),
    .o_chk_data (w_chk_d),
    .o_chk_back (w_chk_back),
    .i_clr      (w_clr),
    .i_wr       (w_wr),
    .i_wr_a     (bus.cfg_a),
    .i_wr_b     (bus.cfg_b),
    .i_copy     (w_copy)
  );

  assign w_in_ok      = in_range(int'(bus.in_letter), ALPHA);
  assign w_pair_ok    = in_range(int'(bus.cfg_a), ALPHA) && in_range(int'(bus.cfg_b), ALPHA)
                        && (bus.cfg_a != bus.cfg_b);
  assign w_entry_fail = (w_chk_d == '0) || (w_chk_d == r_idx) || (w_chk_back != r_idx);

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    w_bad_set  = 1'b0;
    w_bad_clr  = 1'b0;
    w_clr      = 1'b0;
    w_wr       = 1'b0;
    w_copy     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          w_clr     = 1'b1;
          w_bad_clr = 1'b1;
          w_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.cfg_valid) begin
          w_wr      = w_pair_ok;
          w_bad_set = !w_pair_ok;
        end
        if (bus.cfg_commit) begin
          w_next     = ST_CHECK;
          w_idx_next = W'(1);
        end
      end
      ST_CHECK: begin
        w_bad_set = w_entry_fail;
        // The last entry's verdict is folded in directly; r_bad lags by a cycle.
        if (r_idx == W'(ALPHA)) begin
          w_next = (r_bad || w_entry_fail) ? ST_FAIL : ST_APPLY;
        end else begin
          w_idx_next = r_idx + W'(1);
        end
      end
      ST_APPLY: begin
        w_copy = 1'b1;
        w_next = ST_IDLE;
      end
      ST_FAIL: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_bad        <= 1'b0;
      r_ok         <= 1'b0;
      r_fail       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_letter <= '0;
      r_out_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      if (w_bad_clr)      r_bad <= 1'b0;
      else if (w_bad_set) r_bad <= 1'b1;
      r_ok        <= (r_state == ST_APPLY);
      r_fail      <= (r_state == ST_FAIL);
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_letter <= w_in_ok ? w_act_rd : '0;
        r_out_err    <= !w_in_ok;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_letter = r_out_letter;
  assign bus.out_err    = r_out_err;
  assign bus.cfg_busy   = (r_state != ST_IDLE);
  assign bus.cfg_ok     = r_ok;
  assign bus.cfg_fail   = r_fail;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_reflector_prog.sv
// Bench for reflector_prog: random letter streams and wirings checked against
// an array model of the active/shadow tables.
module tb_reflector_prog;
  import reflector_pkg::*;

  localparam int ALPHA = 26;
  localparam int W     = 5;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  reflector_prog_if #(.W(W)) bus ();

  reflector_prog #(.ALPHA(ALPHA), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         act_m [1:ALPHA];
  int         shd_m [1:ALPHA];
  bit         bad_m;
  logic [W:0] exp_q [$];
  logic [W:0] last_out;
  bit         stream_en  = 1'b0;
  int         fix_letter = -1;
  int         perm [ALPHA];

  function automatic int ref_default(input int i);
    return (i <= ALPHA / 2) ? i + ALPHA / 2 : i - ALPHA / 2;
  endfunction

  function automatic logic [W:0] ref_translate(input int l);
    if (l >= 1 && l <= ALPHA) return {1'b0, W'(act_m[l])};
    return {1'b1, W'(0)};
  endfunction

  function automatic bit wiring_ok();
    if (bad_m) return 1'b0;
    for (int i = 1; i <= ALPHA; i++) begin
      if (shd_m[i] == 0 || shd_m[i] == i) return 1'b0;
      if (shd_m[shd_m[i]] != i) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic shuffle_perm();
    int j, t;
    for (int i = 0; i < ALPHA; i++) perm[i] = i + 1;
    for (int i = ALPHA - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  // One clock: drive a letter (or idle), then check the registered output.
  task automatic tick_with(input bit v, input int l);
    logic [W:0] e, got;
    bus.in_valid  = v;
    bus.in_letter = W'(l);
    if (v) exp_q.push_back(ref_translate(l));
    @(posedge clk); #1;
    got = {bus.out_err, bus.out_letter};
    checks++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (bus.out_valid !== 1'b1 || got !== e) begin
        errors++;
        $display("FAIL translate: in=%0d got valid=%b err_letter=%h, want valid=1 err_letter=%h",
                 l, bus.out_valid, got, e);
      end
      last_out = e;
    end else if (bus.out_valid !== 1'b0 || got !== last_out) begin
      errors++;
      $display("FAIL hold: got valid=%b err_letter=%h, want valid=0 err_letter=%h",
               bus.out_valid, got, last_out);
    end
  endtask

  task automatic tick();
    tick_with(stream_en, (fix_letter >= 0) ? fix_letter : int'($urandom_range(0, ALPHA + 2)));
  endtask

  task automatic reset_dut();
    bus.in_valid = 1'b0; bus.in_letter = '0;
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_commit = 1'b0;
    bus.cfg_a = '0; bus.cfg_b = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_letter, bus.out_err, bus.cfg_busy, bus.cfg_ok, bus.cfg_fail} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%0d e=%b busy=%b ok=%b fail=%b, want all 0",
               bus.out_valid, bus.out_letter, bus.out_err, bus.cfg_busy, bus.cfg_ok, bus.cfg_fail);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %s want ST_IDLE", dbg_state.name());
    end
    exp_q.delete();
    last_out = '0;
    for (int i = 1; i <= ALPHA; i++) begin act_m[i] = ref_default(i); shd_m[i] = 0; end
    bad_m = 1'b0;
    rst = 1'b0;
  endtask

  task automatic cfg_begin();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 1; i <= ALPHA; i++) shd_m[i] = 0;
    bad_m = 1'b0;
    checks++;
    if (bus.cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_start_busy: got %b want 1", bus.cfg_busy);
    end
  endtask

  task automatic wait_result();
    bit exp_ok;
    exp_ok = wiring_ok();
    for (int j = 1; j <= ALPHA; j++) begin
      tick();
      checks++;
      if (bus.cfg_busy !== 1'b1 || bus.cfg_ok !== 1'b0 || bus.cfg_fail !== 1'b0) begin
        errors++;
        $display("FAIL cfg_wait: cycle %0d got busy=%b ok=%b fail=%b, want 1 0 0",
                 j, bus.cfg_busy, bus.cfg_ok, bus.cfg_fail);
      end
    end
    tick();
    checks++;
    if ({bus.cfg_busy, bus.cfg_ok, bus.cfg_fail} !== {1'b0, exp_ok, !exp_ok}) begin
      errors++;
      $display("FAIL cfg_result: got busy=%b ok=%b fail=%b, want 0 %b %b",
               bus.cfg_busy, bus.cfg_ok, bus.cfg_fail, exp_ok, !exp_ok);
    end
    if (exp_ok) for (int i = 1; i <= ALPHA; i++) act_m[i] = shd_m[i];
    tick();
    checks++;
    if (bus.cfg_ok !== 1'b0 || bus.cfg_fail !== 1'b0) begin
      errors++;
      $display("FAIL cfg_pulse_len: got ok=%b fail=%b want 0 0", bus.cfg_ok, bus.cfg_fail);
    end
  endtask

  task automatic cfg_pair(input int a, input int b, input bit commit);
    bus.cfg_valid = 1'b1; bus.cfg_a = W'(a); bus.cfg_b = W'(b); bus.cfg_commit = commit;
    if (a >= 1 && a <= ALPHA && b >= 1 && b <= ALPHA && a != b) begin
      shd_m[a] = b; shd_m[b] = a;
    end else begin
      bad_m = 1'b1;
    end
    tick();
    bus.cfg_valid = 1'b0; bus.cfg_commit = 1'b0;
    if (commit) wait_result();
  endtask

  task automatic cfg_commit_now();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    wait_result();
  endtask

  task automatic check_letter(input string name, input logic [W-1:0] want);
    checks++;
    if (bus.out_letter !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, bus.out_letter, want);
    end
  endtask

  task automatic test_reset();
    reset_dut();
  endtask

  task automatic test_default_map();
    int tin [6]  = '{1, 13, 14, 26, 0, 27};
    int tout [6] = '{14, 26, 1, 13, 0, 0};
    int terr [6] = '{0, 0, 0, 0, 1, 1};
    stream_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fix_letter = tin[i];
      tick();
      checks++;
      if ({bus.out_err, bus.out_letter} !== {terr[i][0], W'(tout[i])}) begin
        errors++;
        $display("FAIL default_map: in=%0d got letter=%0d err=%b want letter=%0d err=%0d",
                 tin[i], bus.out_letter, bus.out_err, tout[i], terr[i]);
      end
    end
    stream_en = 1'b0; fix_letter = -1;
    tick(); tick();
  endtask

  task automatic test_load_short();
    cfg_begin();
    for (int i = 1; i <= 12; i++) cfg_pair(i, ALPHA + 1 - i, 1'b0);
    cfg_commit_now();
    stream_en = 1'b1; fix_letter = 1;
    tick();
    check_letter("short_keeps_default", 5'd14);
    stream_en = 1'b0; fix_letter = -1;
  endtask

  task automatic test_overwrite();
    cfg_begin();
    cfg_pair(1, 2, 1'b0);
    cfg_pair(1, 3, 1'b0);
    for (int i = 4; i <= 24; i += 2) cfg_pair(i, i + 1, 1'b0);
    cfg_commit_now();
  endtask

  task automatic test_self_pair();
    cfg_begin();
    for (int i = 1; i <= ALPHA / 2; i++) begin
      cfg_pair(i, ALPHA + 1 - i, 1'b0);
      if (i == 6) cfg_pair(4, 4, 1'b0);
    end
    cfg_commit_now();
  endtask

  task automatic test_stream_commit_with_valid();
    stream_en = 1'b1; fix_letter = -1;
    shuffle_perm();
    cfg_begin();
    for (int j = 0; j < ALPHA / 2; j++)
      cfg_pair(perm[2*j], perm[2*j+1], j == ALPHA / 2 - 1);
    stream_en = 1'b0;
  endtask

  task automatic test_load_ok();
    stream_en = 1'b1; fix_letter = 1;
    cfg_begin();
    for (int i = 1; i <= ALPHA / 2; i++) cfg_pair(i, ALPHA + 1 - i, 1'b0);
    cfg_commit_now();
    check_letter("reverse_1", 5'd26);
    fix_letter = 5;
    tick();
    check_letter("reverse_5", 5'd22);
    stream_en = 1'b0; fix_letter = -1;
  endtask

  task automatic test_random();
    int kind, drop;
    stream_en = 1'b1; fix_letter = -1;
    for (int it = 0; it < 8; it++) begin
      shuffle_perm();
      kind = int'($urandom_range(0, 4));
      drop = int'($urandom_range(0, ALPHA / 2 - 1));
      cfg_begin();
      for (int j = 0; j < ALPHA / 2; j++) begin
        if (!(kind == 1 && j == drop)) cfg_pair(perm[2*j], perm[2*j+1], 1'b0);
        if (j == 6) begin
          case (kind)
            2: cfg_pair(perm[3], perm[3], 1'b0);
            3: cfg_pair(int'($urandom_range(ALPHA + 1, 31)), perm[5], 1'b0);
            4: cfg_pair(perm[0], perm[2], 1'b0);
            default: ;
          endcase
        end
      end
      cfg_commit_now();
    end
    stream_en = 1'b0;
  endtask

  task automatic test_reset_mid_check();
    stream_en = 1'b0;
    cfg_begin();
    for (int i = 1; i <= ALPHA / 2; i++) cfg_pair(i, i + ALPHA / 2 + ((i == 1) ? 1 : 0) - ((i == 2) ? 1 : 0), 1'b0);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    reset_dut();
    for (int j = 0; j < ALPHA + 4; j++) begin
      tick();
      checks++;
      if (bus.cfg_busy !== 1'b0 || bus.cfg_ok !== 1'b0 || bus.cfg_fail !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort: cycle %0d got busy=%b ok=%b fail=%b want 0 0 0",
                 j, bus.cfg_busy, bus.cfg_ok, bus.cfg_fail);
      end
    end
    stream_en = 1'b1; fix_letter = 1;
    tick();
    check_letter("reset_restores_default", 5'd14);
    fix_letter = -1;
    for (int j = 0; j < 20; j++) tick();
    stream_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_default_map();
    test_load_short();
    test_overwrite();
    test_self_pair();
    test_stream_commit_with_valid();
    test_load_ok();
    test_random();
    test_reset_mid_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
